array_frame_collector: RTL and testbench
========================================

// Module: array_frame_collector
// PURPOSE
//  Receive end of the array-frame stream interface. Accepts element words one per beat
//  (valid/ready, last-tagged) and assembles them into a [1:D1][1:D2][D3:1] unpacked frame
//  of packed [1:0][1:2][2:0] words. Presents each complete frame on a frame-level
//  valid/ready handshake. Sits between the serial link and wide-array consumers.
// PARAMETERS
//  D1      4   outer frame dimension
//  D2      3   middle frame dimension
//  D3      2   inner frame dimension (fastest-varying in stream order)
//  CNT_W   16  width of the good-frame statistics counter
// PORTS
//  clk          in   1       single clock, all logic rising-edge
//  rst          in   1       synchronous reset, active-high
//  in_valid     in   1       element beat valid
//  in_ready     out  1       collector can accept a beat
//  in_data      in   elem_t  element word, 12b packed [1:0][1:2][2:0]
//  in_last      in   1       final beat of a frame
//  frame_valid  out  1       complete frame held on frame_data
//  frame_ready  in   1       consumer takes frame
//  frame_data   out  elem_t  unpacked [1:D1][1:D2][D3:1] assembled frame
//  err_len      out  1       one-cycle pulse: frame length error
//  err_unknown  out  1       one-cycle pulse: X/Z beat seen (ARRAY_FRAME_XCHK_EN only, else 0)
//  good_frames  out  CNT_W   saturating count of frames delivered
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): state=COLLECT, idx=0, in_ready=1, frame_valid=0,
//    err_len=0, err_unknown=0, good_frames=0, frame buffer all '0. rst wins over all inputs.
//  - Beat accepted when in_valid&&in_ready. Stream order: D3 fastest, then D2, then D1
//    (beat k -> [k/(D2*D3)+1][(k/D3)%D2+1][D3-(k%D3)]). N = D1*D2*D3 (24 default).
//  - States:
//    COLLECT: in_ready=1. Each beat writes buffer[idx], idx++.
//      last && idx==N-1 -> HOLD; frame_valid=1 next cycle (1-cycle latency from last beat).
//      last && idx<N-1  -> err_len pulse, idx=0, stay COLLECT (partial frame discarded).
//      !last && idx==N-1 -> err_len pulse, -> DRAIN.
//    HOLD: in_ready=0, frame_valid=1, frame_data stable.
//      frame_ready -> COLLECT, idx=0, good_frames++ (saturates at all-ones).
//      in_ready returns to 1 the cycle after the transfer; no same-cycle bypass.
//    DRAIN: in_ready=1, beats discarded, buffer untouched; accepted last beat -> COLLECT,
//      idx=0. No further err_len during DRAIN.
//  - frame_data only meaningful while frame_valid; buffer is overwritten in place during
//    COLLECT.
//  - N==1: a single last beat completes a frame; a non-last beat errors into DRAIN.
//  - in_valid low stalls collection indefinitely; idx holds.
//  - err_len and err_unknown are pulses, never held; both may fire in the same cycle.
// CONFIGURATION
//  `ARRAY_FRAME_XCHK_EN defined: accepted beat with $isunknown(in_data) or $isunknown(in_last)
//    -> err_unknown pulse, frame discarded as for a length error: COLLECT with idx=0 when
//    in_last==1, otherwise DRAIN. A last value of X/Z counts as not-last.
//  Not defined: no X/Z check; X/Z bits stored verbatim; err_unknown tied 0.
// STRUCTURE
//  Package array_frame_pkg: elem_t (logic [1:0][1:2][2:0]), state enum {COLLECT,HOLD,DRAIN},
//    default D1/D2/D3 localparams, index-mapping function beat->(i,j,k).
//  One sub-module array_frame_idx: beat counter with wrap and per-dimension
//    (i,j,k) decode; parent holds FSM, buffer and counters.
// TESTING
//  1. Reset, 24 beats data=k, last on beat 23 -> frame_valid 1 cycle later,
//     frame_data[1][1][2]=0, [4][3][1]=23, good_frames=1 after frame_ready.
//  2. last on beat 10 -> err_len pulse on that cycle, in_ready stays 1, next 24-beat
//     frame collected correctly.
//  3. 26 beats, last on beat 25 -> err_len pulse at beat 23, beats 24-25 discarded,
//     no frame_valid, next frame correct.
//  4. Hold frame_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, frame_data stable;
//     on frame_ready=1, in_ready=1 the following cycle.
//  5. rst=1 mid-frame at beat 12 -> all outputs reset values next cycle,
//     subsequent full frame correct.
//  6. XCHK_EN: beat 5 data='x -> err_unknown pulse, DRAIN until last, no frame;
//     without macro same stimulus -> frame delivered with X at [1][3][1].

Source files
------------

// File: rtl/array_frame_pkg.sv
// Shared types for the array-frame collector: element word, FSM states,
// default frame dimensions and the beat -> (i,j,k) frame position mapping.
package array_frame_pkg;

    typedef logic [1:0][1:2][2:0] elem_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam int DEF_D1    = 4;
    localparam int DEF_D2    = 3;
    localparam int DEF_D3    = 2;
    localparam int DEF_CNT_W = 16;

    typedef struct packed {
        logic [7:0] i;
        logic [7:0] j;
        logic [7:0] k;
    } pos_t;

    // D3 varies fastest in stream order, and its index runs downwards.
    function automatic pos_t beat_pos(input int beat, input int d2, input int d3);
        pos_t p;
        p.i = 8'(beat / (d2 * d3) + 32'sd1);
        p.j = 8'((beat / d3) % d2 + 32'sd1);
        p.k = 8'(d3 - (beat % d3));
        return p;
    endfunction

endpackage

// File: rtl/array_frame_idx.sv
// Beat counter for one frame: clears or wraps after N beats and decodes the
// current beat into its (i,j,k) frame position.
module array_frame_idx
    import array_frame_pkg::*;
#(
    parameter int D1 = DEF_D1,
    parameter int D2 = DEF_D2,
    parameter int D3 = DEF_D3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic last_o,
    output pos_t pos_o
);

    localparam int N     = D1 * D2 * D3;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    assign last_o = (idx_q == IDX_W'(N - 1));
    assign pos_o  = beat_pos(32'(idx_q), D2, D3);

    // Next beat index: clear has priority, increment wraps after the last position.
    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (inc_i) begin
            idx_d = last_o ? '0 : idx_q + IDX_W'(1);
        end else begin
            idx_d = idx_q;
        end
    end

    // Beat index register.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/array_frame_collector.sv
// Assembles a stream of element beats into a [1:D1][1:D2][D3:1] frame and hands it
// out on a frame-level valid/ready handshake. Optional X/Z beat check: ARRAY_FRAME_XCHK_EN.
module array_frame_collector
    import array_frame_pkg::*;
#(
    parameter int D1    = DEF_D1,
    parameter int D2    = DEF_D2,
    parameter int D3    = DEF_D3,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  elem_t            in_data,
    input  logic             in_last,
    output logic             frame_valid,
    input  logic             frame_ready,
    output elem_t            frame_data [1:D1][1:D2][D3:1],
    output logic             err_len,
    output logic             err_unknown,
    output logic [CNT_W-1:0] good_frames
);

    state_t           state_q, state_d;
    elem_t            buf_q [1:D1][1:D2][D3:1];
    logic             err_len_q, err_len_d;
    logic             err_unknown_q, err_unknown_d;
    logic [CNT_W-1:0] good_q, good_d;
    logic             accept_s, bad_s, last_eff_s, at_last_s;
    logic             clr_s, inc_s, wr_s;
    pos_t             pos_s;

    array_frame_idx #(.D1(D1), .D2(D2), .D3(D3)) u_idx (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr_s),
        .inc_i  (inc_s),
        .last_o (at_last_s),
        .pos_o  (pos_s)
    );

    assign in_ready    = (state_q != HOLD);
    assign frame_valid = (state_q == HOLD);
    assign accept_s    = in_valid && in_ready;
    assign frame_data  = buf_q;
    assign err_len     = err_len_q;
    assign err_unknown = err_unknown_q;
    assign good_frames = good_q;

`ifdef ARRAY_FRAME_XCHK_EN
    assign bad_s      = $isunknown(in_data) || $isunknown(in_last);
    assign last_eff_s = (in_last === 1'b1);
`else
    assign bad_s      = 1'b0;
    assign last_eff_s = in_last;
`endif

    // Frame FSM next state, beat bookkeeping and error pulses.
    always_comb begin
        state_d       = state_q;
        err_len_d     = 1'b0;
        err_unknown_d = 1'b0;
        good_d        = good_q;
        clr_s         = 1'b0;
        inc_s         = 1'b0;
        wr_s          = 1'b0;
        case (state_q)
            COLLECT: begin
                if (!accept_s) begin
                    state_d = COLLECT;
                end else if (bad_s) begin
                    err_unknown_d = 1'b1;
                    clr_s         = 1'b1;
                    state_d       = last_eff_s ? COLLECT : DRAIN;
                end else begin
                    wr_s  = 1'b1;
                    inc_s = 1'b1;
                    if (last_eff_s && at_last_s) begin
                        state_d = HOLD;
                    end else if (last_eff_s || at_last_s) begin
                        err_len_d = 1'b1;
                        clr_s     = 1'b1;
                        state_d   = last_eff_s ? COLLECT : DRAIN;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            HOLD: begin
                if (frame_ready) begin
                    state_d = COLLECT;
                    clr_s   = 1'b1;
                    good_d  = (good_q == {CNT_W{1'b1}}) ? good_q : good_q + CNT_W'(1);
                end else begin
                    state_d = HOLD;
                end
            end
            DRAIN: begin
                err_unknown_d = accept_s && bad_s;
                if (accept_s && last_eff_s) begin
                    state_d = COLLECT;
                    clr_s   = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = COLLECT;
                clr_s   = 1'b1;
            end
        endcase
    end

    // State, error pulses and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= COLLECT;
            err_len_q     <= 1'b0;
            err_unknown_q <= 1'b0;
            good_q        <= '0;
        end else begin
            state_q       <= state_d;
            err_len_q     <= err_len_d;
            err_unknown_q <= err_unknown_d;
            good_q        <= good_d;
        end
    end

    // Frame buffer, written in place at the decoded position of each accepted beat.
    always_ff @(posedge clk) begin
        for (int i = 1; i <= D1; i++) begin
            for (int j = 1; j <= D2; j++) begin
                for (int k = 1; k <= D3; k++) begin
                    if (rst) begin
                        buf_q[i][j][k] <= '0;
                    end else if (wr_s && pos_s.i == 8'(i) && pos_s.j == 8'(j)
                                 && pos_s.k == 8'(k)) begin
                        buf_q[i][j][k] <= in_data;
                    end else begin
                        buf_q[i][j][k] <= buf_q[i][j][k];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_array_frame_collector.sv
// Directed self-checking bench for array_frame_collector (default 4x3x2 frame).
module tb_array_frame_collector;
    import array_frame_pkg::*;

`ifdef ARRAY_FRAME_XCHK_EN
    localparam bit XCHK = 1'b1;
`else
    localparam bit XCHK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    elem_t       in_data;
    logic        in_last;
    logic        frame_valid;
    logic        frame_ready;
    elem_t       frame_data [1:4][1:3][2:1];
    logic        err_len;
    logic        err_unknown;
    logic [15:0] good_frames;

    int n_checks;
    int n_fail;

    array_frame_collector dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .err_len     (err_len),
        .err_unknown (err_unknown),
        .good_frames (good_frames)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams n beats (data = base+k), last on beat last_at, X data on beat x_at.
    task automatic send_frame(input int n, input int last_at, input int base,
                              input int err_at, input int x_at);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_last  = (k == last_at);
            if (k == x_at) in_data = 'x;
            else           in_data = 12'(base + k);
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
            chk("err_len_beat", 32'(err_len), 32'(k == err_at));
            chk("err_unknown_beat", 32'(err_unknown), 32'(XCHK && k == x_at));
        end
    endtask

    task automatic take_frame();
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        in_last     = 1'b0;
        frame_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_frame_valid", 32'(frame_valid), 32'd0);
        chk("rst_err_len", 32'(err_len), 32'd0);
        chk("rst_good", 32'(good_frames), 32'd0);
        chk("rst_buf", 32'(frame_data[4][3][1]), 32'd0);

        // 1: plain frame
        send_frame(24, 23, 0, -1, -1);
        chk("t1_fv", 32'(frame_valid), 32'd1);
        chk("t1_in_ready", 32'(in_ready), 32'd0);
        chk("t1_d112", 32'(frame_data[1][1][2]), 32'd0);
        chk("t1_d212", 32'(frame_data[2][1][2]), 32'd6);
        chk("t1_d431", 32'(frame_data[4][3][1]), 32'd23);
        take_frame();
        chk("t1_good", 32'(good_frames), 32'd1);
        chk("t1_fv_after", 32'(frame_valid), 32'd0);
        chk("t1_in_ready_after", 32'(in_ready), 32'd1);

        // 2: short frame, then a good one
        send_frame(11, 10, 100, 10, -1);
        chk("t2_in_ready", 32'(in_ready), 32'd1);
        chk("t2_fv", 32'(frame_valid), 32'd0);
        tick();
        chk("t2_err_pulse", 32'(err_len), 32'd0);
        send_frame(24, 23, 200, -1, -1);
        chk("t2_fv2", 32'(frame_valid), 32'd1);
        chk("t2_d112", 32'(frame_data[1][1][2]), 32'd200);
        chk("t2_d321", 32'(frame_data[3][2][1]), 32'd215);
        chk("t2_d431", 32'(frame_data[4][3][1]), 32'd223);
        take_frame();

        // 3: long frame drained, then a good one
        send_frame(26, 25, 300, 23, -1);
        chk("t3_fv", 32'(frame_valid), 32'd0);
        chk("t3_in_ready", 32'(in_ready), 32'd1);
        send_frame(24, 23, 400, -1, -1);
        chk("t3_fv2", 32'(frame_valid), 32'd1);
        chk("t3_d112", 32'(frame_data[1][1][2]), 32'd400);
        chk("t3_d431", 32'(frame_data[4][3][1]), 32'd423);
        take_frame();

        // 4: back-pressure on the frame side
        send_frame(24, 23, 500, -1, -1);
        in_valid = 1'b1;
        in_data  = 12'd999;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t4_in_ready", 32'(in_ready), 32'd0);
            chk("t4_fv", 32'(frame_valid), 32'd1);
            chk("t4_d431", 32'(frame_data[4][3][1]), 32'd523);
        end
        in_valid = 1'b0;
        take_frame();
        chk("t4_in_ready_after", 32'(in_ready), 32'd1);
        chk("t4_good", 32'(good_frames), 32'd4);

        // 5: reset mid-frame
        send_frame(12, -1, 600, -1, -1);
        in_valid = 1'b1;
        in_data  = 12'd777;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        chk("t5_fv", 32'(frame_valid), 32'd0);
        chk("t5_good", 32'(good_frames), 32'd0);
        chk("t5_buf", 32'(frame_data[1][1][2]), 32'd0);
        send_frame(24, 23, 700, -1, -1);
        chk("t5_d112", 32'(frame_data[1][1][2]), 32'd700);
        chk("t5_d431", 32'(frame_data[4][3][1]), 32'd723);
        take_frame();
        chk("t5_good_after", 32'(good_frames), 32'd1);

        // 6: unknown data on beat 5
        send_frame(24, 23, 800, -1, 5);
        chk("t6_fv", 32'(frame_valid), XCHK ? 32'd0 : 32'd1);
        chk("t6_d431", 32'(frame_data[4][3][1]), XCHK ? 32'd723 : 32'd823);
        take_frame();
        chk("t6_good", 32'(good_frames), XCHK ? 32'd1 : 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
